alu_pipe: RTL

//  Parametrised, pipelined successor to the single-cycle ALU. Eight opcodes over WIDTH-bit operands.

---
 rtl/alu_pipe.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/alu_pipe.sv
// -----------------------------------------------------------------------------
// alu_pipe
//   Two-stage pipelined ALU with eight opcodes over WIDTH-bit operands.
//   Stage 1 captures the accepted operand beat. Stage 2 computes the result and
//   the registered {N,V,C,Z} status flags and presents them downstream.
//   The latency is fixed and the pipeline accepts one beat per cycle.
//
//   Handshake (both sides): a beat transfers on a rising edge where
//   valid && ready are both high. The producer holds valid and the payload
//   stable until the transfer. in_ready is a combinational function of v1 and
//   out_ready, so a full pipe with a draining consumer still accepts a new
//   beat in the same cycle.
//
//   Optional feature: define ALU_ACC_EN to add an accumulator. When acc_sel is
//   captured high, operand A is the result of the previous beat instead of x.
//   Without the macro, acc_sel is ignored.
//
// Ports
//   aclk, aresetn         clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   operand beat handshake
//   x, y, opcode, acc_sel operand beat payload
//   out_valid / out_ready result beat handshake
//   result, status        registered result and {N,V,C,Z}
// -----------------------------------------------------------------------------
module alu_pipe #(
  parameter int WIDTH = 13
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [2:0]       opcode,
  input  logic             acc_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       status
);

  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SHL = 3'd5,
    OP_SHR = 3'd6,
    OP_MUL = 3'd7
  } op_e;

  // Stage 1 registers
  logic             v1_q, v1_d;
  logic [WIDTH-1:0] x1_q, x1_d;
  logic [WIDTH-1:0] y1_q, y1_d;
  logic [2:0]       op1_q, op1_d;

  // Stage 2 registers
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       status_q, status_d;

  logic adv1, adv2;

`ifdef ALU_ACC_EN
  logic             sel1_q, sel1_d;
  logic [WIDTH-1:0] acc_q, acc_d;
`else
  logic unused_acc_sel;
  assign unused_acc_sel = acc_sel;
`endif

  // Datapath intermediates
  logic [WIDTH-1:0]   op_a, op_b;
  logic [WIDTH:0]     sum_w, diff_w;
  logic [2*WIDTH-1:0] prod_w;
  logic [WIDTH:0]     shl_w, shr_w;
  logic [SHW-1:0]     shamt;
  logic               shift_big;
  logic [WIDTH-1:0]   calc_res;
  logic               calc_c, calc_v;

  // Stage 2 advances when empty or when its beat is being taken; stage 1
  // advances when empty or when stage 2 advances.
  always_comb begin
    adv2     = !out_valid_q || out_ready;
    adv1     = !v1_q || adv2;
    in_ready = adv1;
  end

  // Stage 1 next state
  always_comb begin
    v1_d  = v1_q;
    x1_d  = x1_q;
    y1_d  = y1_q;
    op1_d = op1_q;
`ifdef ALU_ACC_EN
    sel1_d = sel1_q;
`endif
    if (adv1) begin
      v1_d = in_valid;
      if (in_valid) begin
        x1_d  = x;
        y1_d  = y;
        op1_d = opcode;
`ifdef ALU_ACC_EN
        sel1_d = acc_sel;
`endif
      end
    end
  end

  // Stage 2 combinational ALU
  always_comb begin
`ifdef ALU_ACC_EN
    op_a = sel1_q ? acc_q : x1_q;
`else
    op_a = x1_q;
`endif
    op_b   = y1_q;
    sum_w  = {1'b0, op_a} + {1'b0, op_b};
    // Bit WIDTH of the difference is the unsigned borrow.
    diff_w = {1'b0, op_a} - {1'b0, op_b};
    prod_w = {{WIDTH{1'b0}}, op_a} * {{WIDTH{1'b0}}, op_b};
    shamt     = op_b[SHW-1:0];
    shift_big = (op_b >= WIDTH'(WIDTH));
    // The extra bit catches the last bit shifted out; it stays 0 for a zero shift.
    shl_w  = {1'b0, op_a} << shamt;
    shr_w  = {op_a, 1'b0} >> shamt;

    calc_res = '0;
    calc_c   = 1'b0;
    calc_v   = 1'b0;
    case (op_e'(op1_q))
      OP_ADD: begin
        calc_res = sum_w[WIDTH-1:0];
        calc_c   = sum_w[WIDTH];
        calc_v   = (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                   (sum_w[WIDTH-1] != op_a[WIDTH-1]);
      end
      OP_SUB: begin
        calc_res = diff_w[WIDTH-1:0];
        calc_c   = diff_w[WIDTH];
        calc_v   = (op_a[WIDTH-1] != op_b[WIDTH-1]) &&
                   (diff_w[WIDTH-1] != op_a[WIDTH-1]);
      end
      OP_AND: calc_res = op_a & op_b;
      OP_OR:  calc_res = op_a | op_b;
      OP_XOR: calc_res = op_a ^ op_b;
      OP_SHL: begin
        if (!shift_big) begin
          calc_res = shl_w[WIDTH-1:0];
          calc_c   = shl_w[WIDTH];
        end
      end
      OP_SHR: begin
        if (!shift_big) begin
          calc_res = shr_w[WIDTH:1];
          calc_c   = shr_w[0];
        end
      end
      OP_MUL: begin
        calc_res = prod_w[WIDTH-1:0];
        calc_c   = |prod_w[2*WIDTH-1:WIDTH];
      end
      default: begin
        calc_res = '0;
      end
    endcase
  end

  // Stage 2 next state
  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    status_d    = status_q;
`ifdef ALU_ACC_EN
    acc_d = acc_q;
`endif
    if (adv2) begin
      out_valid_d = v1_q;
      if (v1_q) begin
        result_d = calc_res;
        status_d = {calc_res[WIDTH-1], calc_v, calc_c, (calc_res == '0)};
`ifdef ALU_ACC_EN
        acc_d = calc_res;
`endif
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      v1_q        <= 1'b0;
      x1_q        <= '0;
      y1_q        <= '0;
      op1_q       <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      status_q    <= '0;
`ifdef ALU_ACC_EN
      sel1_q <= 1'b0;
      acc_q  <= '0;
`endif
    end else begin
      v1_q        <= v1_d;
      x1_q        <= x1_d;
      y1_q        <= y1_d;
      op1_q       <= op1_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      status_q    <= status_d;
`ifdef ALU_ACC_EN
      sel1_q <= sel1_d;
      acc_q  <= acc_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign status    = status_q;

endmodule
